// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: arbiter FSM states and the default line width.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  localparam int unsigned arb_line_width = 256;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder; first requester at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  localparam int unsigned N = NUM_PORTS;

  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_ptr) + i) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of NUM_PORTS line requesters onto one downstream line port.
// Optional per-port saturating grant counters when ARB_PERF_EN is defined.
module mem_arbiter_rr
  import rv32i_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = int'(arb_line_width),
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
  output logic [LINE_WIDTH-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [LINE_WIDTH-1:0]           mem_wdata,
  input  logic [LINE_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_resp,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  grant_count
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]   req_any;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  assign req_any = req_read | req_write;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req         (req_any),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          addr_d   = req_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d  = req_wdata[pick_idx*LINE_WIDTH +: LINE_WIDTH];
          // A port asserting both read and write is treated as a write.
          write_d  = req_write[pick_idx];
          rr_ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          if (!write_q) rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    req_resp = '0;
    if (state_q == DONE) req_resp[grant_q] = 1'b1;
  end

  assign mem_read    = (state_q == BUSY) && !write_q;
  assign mem_write   = (state_q == BUSY) && write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign req_rdata   = rdata_q;

`ifdef ARB_PERF_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (state_q == IDLE && pick_valid && pick_idx == IDX_W'(p) && cnt_q[p] != '1)
        cnt_d[p] = cnt_q[p] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      grant_count[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr with 4 ports and 3-bit grant counters.
module tb_mem_arbiter_rr;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NP-1:0]    req_read = '0;
  logic [NP-1:0]    req_write = '0;
  logic [NP*AW-1:0] req_address = '0;
  logic [NP*LW-1:0] req_wdata = '0;
  logic [LW-1:0]    req_rdata;
  logic [NP-1:0]    req_resp;
  logic             mem_read, mem_write;
  logic [AW-1:0]    mem_address;
  logic [LW-1:0]    mem_wdata;
  logic [LW-1:0]    mem_rdata = '0;
  logic             mem_resp = 1'b0;
  logic [NP*CW-1:0] grant_count;

  mem_arbiter_rr #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_rdata   (req_rdata),
    .req_resp    (req_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mexp_t;

  typedef struct {
    logic [NP-1:0] resp;
    logic [LW-1:0] rdata;
  } rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];
  int checks = 0;
  int passes = 0;
  int mem_lat = 1;

  function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
    if (a == 32'h0000_1000) return {32{8'hA5}};
    return {8{a ^ 32'hDEAD_BEEF}};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic push_exp(input int p, input bit wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] wd, input logic [LW-1:0] rd);
    logic [NP-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    mq.push_back('{wr, a, wd});
    rq.push_back('{oh, rd});
  endtask

  task automatic wait_resp(input int p, output int n);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (req_resp[p]) return;
    end
    checks++;
    $display("FAIL wait_resp_port%0d: no req_resp within 200 cycles", p);
    n = -1;
  endtask

  task automatic txn(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd,
                     input int lat, output int n);
    @(negedge clk);
    mem_lat = lat;
    req_address[p*AW +: AW] = a;
    req_wdata[p*LW +: LW]   = wd;
    push_exp(p, wr, a, wd, exp_rd);
    req_read[p]  = rd;
    req_write[p] = wr;
    wait_resp(p, n);
    req_read[p]  = 1'b0;
    req_write[p] = 1'b0;
  endtask

  // Downstream model: answers on the mem_lat-th BUSY cycle.
  initial begin
    int busy_cyc;
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_resp = 1'b0;
        busy_cyc = 0;
      end else if ((mem_read || mem_write) && !mem_resp) begin
        busy_cyc++;
        if (busy_cyc >= mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = line_for(mem_address);
        end
      end else begin
        mem_resp = 1'b0;
        busy_cyc = 0;
      end
    end
  end

  // Monitor: downstream requests and upstream responses against the queues.
  initial begin
    bit            active;
    logic          cur_wr;
    logic [AW-1:0] cur_addr;
    mexp_t         m;
    rexp_t         r;
    active = 1'b0;
    cur_wr = 1'b0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (mem_read || mem_write) begin
          chk("mem_rw_exclusive", {255'd0, mem_read & mem_write}, '0);
          if (!active) begin
            active = 1'b1;
            cur_wr = mem_write;
            cur_addr = mem_address;
            if (mq.size() == 0) begin
              checks++;
              $display("FAIL mem_unexpected: got addr %0h expected no transaction", mem_address);
            end else begin
              m = mq.pop_front();
              chk("mem_op_write", {255'd0, mem_write}, {255'd0, m.wr});
              chk("mem_address", {224'd0, mem_address}, {224'd0, m.addr});
              if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
            end
          end else begin
            chk("mem_stable", {223'd0, mem_write, mem_address}, {223'd0, cur_wr, cur_addr});
          end
        end else begin
          active = 1'b0;
        end
        if (req_resp != '0) begin
          if (rq.size() == 0) begin
            checks++;
            $display("FAIL resp_unexpected: got %0h expected 0", req_resp);
          end else begin
            r = rq.pop_front();
            chk("req_resp", {252'd0, req_resp}, {252'd0, r.resp});
            chk("req_rdata", req_rdata, r.rdata);
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [NP*CW-1:0] exp_cnt;

    #1 rst = 1'b1;
    #1;
    chk("rst_req_rdata", req_rdata, '0);
    chk("rst_outputs", {250'd0, req_resp, mem_read, mem_write}, '0);
    chk("rst_mem_addr", {224'd0, mem_address}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_grant_count", {244'd0, grant_count}, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Single read, 4-cycle downstream latency, then minimum latency.
    txn(0, 1'b1, 1'b0, 32'h0000_1000, '0, {32{8'hA5}}, 4, n);
    chk("latency_lat4", 256'(n), 256'd6);
    txn(0, 1'b1, 1'b0, 32'h0000_1000, '0, {32{8'hA5}}, 1, n);
    chk("latency_min", 256'(n), 256'd3);

    // rr_ptr is 1: port 1 write beats port 2 read; write keeps req_rdata.
    @(negedge clk);
    mem_lat = 2;
    req_address[1*AW +: AW] = 32'h0000_2000;
    req_wdata[1*LW +: LW]   = {32{8'h11}};
    req_address[2*AW +: AW] = 32'h0000_3000;
    req_wdata[2*LW +: LW]   = {32{8'h22}};
    push_exp(1, 1'b1, 32'h0000_2000, {32{8'h11}}, {32{8'hA5}});
    push_exp(2, 1'b0, 32'h0000_3000, '0, line_for(32'h0000_3000));
    req_write[1] = 1'b1;
    req_read[2]  = 1'b1;
    wait_resp(1, n);
    req_write[1] = 1'b0;
    wait_resp(2, n);
    req_read[2] = 1'b0;

    // Read and write together on one port: write wins.
    txn(3, 1'b1, 1'b1, 32'h0000_4000, {32{8'h33}}, line_for(32'h0000_3000), 1, n);

    // Reset in the second BUSY cycle discards the transaction.
    @(negedge clk);
    mem_lat = 10;
    req_address[3*AW +: AW] = 32'h0000_5000;
    mq.push_back('{1'b0, 32'h0000_5000, '0});
    req_read[3] = 1'b1;
    for (int k = 0; k < 10 && !mem_read; k++) @(negedge clk);
    chk("midrst_busy_seen", {255'd0, mem_read}, 256'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_read", {254'd0, mem_read, mem_write}, '0);
    chk("midrst_req_resp", {252'd0, req_resp}, '0);
    chk("midrst_req_rdata", req_rdata, '0);
    chk("midrst_mem_addr", {224'd0, mem_address}, '0);
    req_read[3] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // All four ports requesting: grants 0,1,2,3,0.
    mem_lat = 2;
    for (int p = 0; p < NP; p++) req_address[p*AW +: AW] = 32'(32'h100 * (p + 1));
    for (int i = 0; i < 5; i++)
      push_exp(i % NP, 1'b0, 32'(32'h100 * ((i % NP) + 1)), '0,
               line_for(32'(32'h100 * ((i % NP) + 1))));
    req_read = '1;
    for (int i = 0; i < 5; i++) begin
      wait_resp(i % NP, n);
      req_read[i % NP] = 1'b0;
      if (i == 4) begin
        req_read = '0;
      end else begin
        @(negedge clk);
        req_read[i % NP] = 1'b1;
      end
    end

    // Seven more port-0 grants: port 0 totals nine since the last reset.
    for (int i = 0; i < 7; i++)
      txn(0, 1'b1, 1'b0, 32'h0000_0600, '0, line_for(32'h0000_0600), 1, n);

    @(negedge clk);
`ifdef ARB_PERF_EN
    exp_cnt = {3'd1, 3'd1, 3'd1, 3'd7};
`else
    exp_cnt = '0;
`endif
    chk("grant_count", {244'd0, grant_count}, {244'd0, exp_cnt});

    repeat (3) @(negedge clk);
    chk("mem_queue_drained", 256'(mq.size()), '0);
    chk("resp_queue_drained", 256'(rq.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
